// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access engine.
package mem_pkg;
  localparam int XLEN  = 32;
  localparam int VLEN  = 256;
  localparam int BEATS = VLEN / XLEN;
  localparam int CNT_W = $clog2(BEATS);

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    VREAD,
    VWRITE
  } state_t;
endpackage

// File: rtl/memory_access_unit_data_aligner.sv
// Scalar byte-lane steering: store replication / byte enables, load byte select.
module data_aligner
  import mem_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic [1:0]     addrLow,
  input  logic           size,
  input  logic [N-1:0]   storeData,
  output logic [N-1:0]   storeWord,
  output logic [N/8-1:0] byteEna,
  input  logic [2:0]     loadOff,
  input  logic [N-1:0]   loadRaw,
  output logic [N-1:0]   loadData
);
  localparam int BW = N / 8;

  always_comb begin
    storeWord = storeData;
    byteEna   = '1;
    if (size != SIZE_WORD) begin
      storeWord = {BW{storeData[7:0]}};
      byteEna   = BW'(1) << addrLow;
    end
  end

  // loadOff = {size, byte offset} captured when the load was issued
  always_comb begin
    loadData = loadRaw;
    if (loadOff[2] == SIZE_BYTE)
      loadData = N'(loadRaw[{loadOff[1:0], 3'b000} +: 8]);
  end
endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage access engine: scalar word/byte accesses and multi-beat vector
// loads/stores over a single word-wide memory port.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int N = XLEN,
  parameter int V = VLEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           MemReadM,
  input  logic           MemWriteM,
  input  logic           VecDataM,
  input  logic           MemSizeM,
  input  logic [N-1:0]   ALUResultM,
  input  logic [N-1:0]   WriteDataM,
  input  logic [V-1:0]   WriteDataVM,
  input  logic [N-1:0]   ReadData,
  output logic [N-1:0]   AddressData,
  output logic [N/8-1:0] ByteenaData,
  output logic [N-1:0]   WriteData,
  output logic           RdenData,
  output logic           WrenData,
  output logic [N-1:0]   ReadDataM,
  output logic [V-1:0]   ReadDataVM,
  output logic           Busy
);
  state_t           state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prevLane;
  logic [N-1:0]     base;
  logic [V-1:0]     vwbuf;
  logic [V-N-1:0]   vrbuf;
  logic [2:0]       off;

  logic [N-1:0]     alignedAddr;
  logic             anyReq;
  logic             vecReq;
  logic             lastBeat;
  logic [N-1:0]     storeWord;
  logic [N/8-1:0]   storeBe;

  assign alignedAddr = {ALUResultM[N-1:2], 2'b00};
  assign anyReq      = MemReadM | MemWriteM;
  assign vecReq      = (state == IDLE) && VecDataM && anyReq;
  assign lastBeat    = (cnt == CNT_W'(BEATS - 1));
  assign prevLane    = cnt - 1'b1;

  data_aligner #(.N(N)) uAligner (
    .addrLow   (ALUResultM[1:0]),
    .size      (MemSizeM),
    .storeData (WriteDataM),
    .storeWord (storeWord),
    .byteEna   (storeBe),
    .loadOff   (off),
    .loadRaw   (ReadData),
    .loadData  (ReadDataM)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:          if (vecReq) nextState = MemWriteM ? VWRITE : VREAD;
      VREAD, VWRITE: if (lastBeat) nextState = IDLE;
      default:       nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      base  <= '0;
      vwbuf <= '0;
      vrbuf <= '0;
      off   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (vecReq) begin
            base  <= alignedAddr;
            vwbuf <= WriteDataVM;
            cnt   <= CNT_W'(1);
          end else if (MemReadM && !MemWriteM) begin
            off <= {MemSizeM, ALUResultM[1:0]};
          end
        end
        VREAD, VWRITE: begin
          cnt <= lastBeat ? '0 : cnt + 1'b1;
          // data for the beat issued last cycle is on the port now; the top
          // lane is never buffered, it feeds ReadDataVM directly
          if (state == VREAD && cnt != '0)
            vrbuf[prevLane*N +: N] <= ReadData;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    AddressData = alignedAddr;
    ByteenaData = '0;
    WriteData   = storeWord;
    RdenData    = 1'b0;
    WrenData    = 1'b0;
    Busy        = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (VecDataM && anyReq) begin
            WrenData    = MemWriteM;
            RdenData    = !MemWriteM;
            ByteenaData = '1;
            WriteData   = WriteDataVM[N-1:0];
            Busy        = 1'b1;
          end else begin
            WrenData = MemWriteM;
            RdenData = MemReadM && !MemWriteM;
            if (anyReq) ByteenaData = storeBe;
          end
        end
        VREAD, VWRITE: begin
          AddressData = base + (N'(cnt) << 2);
          ByteenaData = '1;
          WriteData   = vwbuf[cnt*N +: N];
          RdenData    = (state == VREAD);
          WrenData    = (state == VWRITE);
          Busy        = !lastBeat;
        end
        default: ;
      endcase
    end
  end

  assign ReadDataVM = {ReadData, vrbuf};
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a small memory model and write log.
module tb_memory_access_unit;
  localparam int N = 32;
  localparam int V = 256;
  localparam int B = V / N;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           MemReadM = 1'b0, MemWriteM = 1'b0, VecDataM = 1'b0, MemSizeM = 1'b0;
  logic [N-1:0]   ALUResultM = '0, WriteDataM = '0;
  logic [V-1:0]   WriteDataVM = '0;
  logic [N-1:0]   ReadData = '0;
  logic [N-1:0]   AddressData;
  logic [N/8-1:0] ByteenaData;
  logic [N-1:0]   WriteData;
  logic           RdenData, WrenData, Busy;
  logic [N-1:0]   ReadDataM;
  logic [V-1:0]   ReadDataVM;

  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int wrStart;
  logic memConst = 1'b0;
  logic [V-1:0] expV;
  logic [N-1:0] a;

  memory_access_unit #(.N(N), .V(V)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .VecDataM(VecDataM), .MemSizeM(MemSizeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteDataVM(WriteDataVM),
    .ReadData(ReadData), .AddressData(AddressData), .ByteenaData(ByteenaData),
    .WriteData(WriteData), .RdenData(RdenData), .WrenData(WrenData),
    .ReadDataM(ReadDataM), .ReadDataVM(ReadDataVM), .Busy(Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RdenData) ReadData <= memConst ? 32'hAABB_CCDD : (AddressData << 1);
    if (WrenData) wrCount <= wrCount + 1;
  end

  task automatic check(input string tag, input logic [V-1:0] got, input logic [V-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noReq();
    MemReadM = 1'b0; MemWriteM = 1'b0; VecDataM = 1'b0; MemSizeM = 1'b0;
  endtask

  initial begin
    // requests held during reset must not reach the port
    MemWriteM = 1'b1; VecDataM = 1'b1;
    #2;
    check("rst_busy", V'(Busy), V'(0));
    check("rst_wren", V'(WrenData), V'(0));
    check("rst_rden", V'(RdenData), V'(0));
    check("rst_be", V'(ByteenaData), V'(0));
    check("rst_vrbuf", V'(ReadDataVM[V-N-1:0]), V'(0));
    tick();
    noReq();
    rst = 1'b1;

    // scalar word store
    tick();
    MemWriteM = 1'b1; ALUResultM = 32'h10; WriteDataM = 32'hDEAD_BEEF; MemSizeM = 1'b0;
    #2;
    check("sw_wren", V'(WrenData), V'(1));
    check("sw_addr", V'(AddressData), V'(32'h10));
    check("sw_be", V'(ByteenaData), V'(4'b1111));
    check("sw_data", V'(WriteData), V'(32'hDEAD_BEEF));
    check("sw_busy", V'(Busy), V'(0));

    // scalar byte store
    tick();
    ALUResultM = 32'h13; WriteDataM = 32'h1234_5678; MemSizeM = 1'b1;
    #2;
    check("sb_be", V'(ByteenaData), V'(4'b1000));
    check("sb_data", V'(WriteData), V'(32'h7878_7878));
    check("sb_addr", V'(AddressData), V'(32'h10));

    // scalar loads back to back
    memConst = 1'b1;
    tick();
    MemWriteM = 1'b0; MemReadM = 1'b1; MemSizeM = 1'b1; ALUResultM = 32'h13;
    #2;
    check("lb_rden", V'(RdenData), V'(1));
    check("lb_wren", V'(WrenData), V'(0));
    tick();
    MemSizeM = 1'b0; ALUResultM = 32'h10;
    #2;
    check("lb_byte3", V'(ReadDataM), V'(32'h0000_00AA));
    tick();
    MemSizeM = 1'b1; ALUResultM = 32'h11;
    #2;
    check("lw_word", V'(ReadDataM), V'(32'hAABB_CCDD));
    tick();
    noReq();
    #2;
    check("lb_byte1", V'(ReadDataM), V'(32'h0000_00CC));
    check("idle_rden", V'(RdenData), V'(0));
    memConst = 1'b0;

    // vector store, request dropped and data scrambled after issue
    tick();
    wrStart = wrCount;
    MemWriteM = 1'b1; VecDataM = 1'b1; ALUResultM = 32'h100;
    for (int k = 0; k < B; k++) WriteDataVM[k*N +: N] = 32'h1111_1111 * (k + 1);
    for (int k = 0; k < B; k++) begin
      if (k > 0) tick();
      if (k == 1) begin noReq(); WriteDataVM = '1; ALUResultM = 32'h0; end
      #2;
      check($sformatf("vs_wren%0d", k), V'(WrenData), V'(1));
      check($sformatf("vs_addr%0d", k), V'(AddressData), V'(32'h100 + 4 * k));
      check($sformatf("vs_data%0d", k), V'(WriteData), V'(32'h1111_1111 * (k + 1)));
      check($sformatf("vs_busy%0d", k), V'(Busy), V'(k < B - 1));
    end
    tick();
    #2;
    check("vs_done_wren", V'(WrenData), V'(0));
    check("vs_done_busy", V'(Busy), V'(0));
    check("vs_nwrites", V'(wrCount - wrStart), V'(B));

    // vector load at 0x200, then back-to-back load at 0x300
    tick();
    MemReadM = 1'b1; VecDataM = 1'b1; ALUResultM = 32'h200;
    for (int k = 0; k < B; k++) begin
      if (k > 0) tick();
      if (k == 1) noReq();
      #2;
      check($sformatf("vl_rden%0d", k), V'(RdenData), V'(1));
      check($sformatf("vl_addr%0d", k), V'(AddressData), V'(32'h200 + 4 * k));
      check($sformatf("vl_busy%0d", k), V'(Busy), V'(k < B - 1));
    end
    tick();
    MemReadM = 1'b1; VecDataM = 1'b1; ALUResultM = 32'h300;
    #2;
    for (int k = 0; k < B; k++) expV[k*N +: N] = 32'h400 + 8 * k;
    check("vl_result1", ReadDataVM, expV);
    check("vl2_addr0", V'(AddressData), V'(32'h300));
    check("vl2_busy0", V'(Busy), V'(1));
    for (int k = 1; k < B; k++) begin
      tick();
      if (k == 1) noReq();
    end
    tick();
    #2;
    for (int k = 0; k < B; k++) expV[k*N +: N] = 32'h600 + 8 * k;
    check("vl_result2", ReadDataVM, expV);

    // vector load wrapping past the top of the address space
    tick();
    MemReadM = 1'b1; VecDataM = 1'b1; ALUResultM = 32'hFFFF_FFF0;
    for (int k = 0; k < B; k++) begin
      if (k > 0) tick();
      if (k == 1) noReq();
      #2;
      a = 32'hFFFF_FFF0 + 32'(4 * k);
      expV[k*N +: N] = a << 1;
      check($sformatf("wrap_addr%0d", k), V'(AddressData), V'(a));
    end
    tick();
    #2;
    check("wrap_result", ReadDataVM, expV);

    // reset asserted during beat 3 of a vector store
    tick();
    wrStart = wrCount;
    MemWriteM = 1'b1; VecDataM = 1'b1; ALUResultM = 32'h400;
    for (int k = 0; k < B; k++) WriteDataVM[k*N +: N] = 32'hA000_0000 + k;
    tick();
    noReq();
    tick();
    tick();
    #1;
    check("mid_beat3_addr", V'(AddressData), V'(32'h40C));
    rst = 1'b0;
    #1;
    check("mid_rst_wren", V'(WrenData), V'(0));
    check("mid_rst_busy", V'(Busy), V'(0));
    check("mid_rst_be", V'(ByteenaData), V'(0));
    check("mid_rst_vrbuf", V'(ReadDataVM[V-N-1:0]), V'(0));
    tick();
    tick();
    rst = 1'b1;
    check("mid_nwrites", V'(wrCount - wrStart), V'(3));
    tick();
    MemReadM = 1'b1; ALUResultM = 32'h20; MemSizeM = 1'b0;
    #2;
    check("post_rden", V'(RdenData), V'(1));
    check("post_addr", V'(AddressData), V'(32'h20));
    check("post_busy", V'(Busy), V'(0));
    tick();
    noReq();
    #2;
    check("post_load", V'(ReadDataM), V'(32'h40));
    check("post_nwrites", V'(wrCount - wrStart), V'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
